// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_pkg
//  Purpose  : Shared definitions for the pipeline hazard unit: register-field
//             width, forward select codes, stage record layout, instruction
//             opcode / function-code definitions and the source-match helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package hazard_unit_pkg;

   // Width of a register specifier field (8 architectural registers, R0 = 0).
   localparam int c_reg_w   = 3;

   // Width of one stage record {rd, regWr, memRd}.
   localparam int c_stage_w = c_reg_w + 2;

   // Operand source select driven onto ForwardA / ForwardB.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // register file
      FWD_EX  = 2'b01,   // EX stage result
      FWD_MEM = 2'b10,   // MEM stage result
      FWD_WB  = 2'b11    // WB stage result
   } fwd_sel_e;

   // Primary opcodes of the core's instruction set.
   localparam logic [3:0] c_op_rtype = 4'h0;
   localparam logic [3:0] c_op_addi  = 4'h1;
   localparam logic [3:0] c_op_lw    = 4'h2;
   localparam logic [3:0] c_op_sw    = 4'h3;
   localparam logic [3:0] c_op_beq   = 4'h4;
   localparam logic [3:0] c_op_bne   = 4'h5;
   localparam logic [3:0] c_op_for   = 4'h6;
   localparam logic [3:0] c_op_ret   = 4'h7;
   localparam logic [3:0] c_op_jmp   = 4'h8;

   // Function codes for R-type instructions.
   localparam logic [2:0] c_fn_add = 3'h0;
   localparam logic [2:0] c_fn_sub = 3'h1;
   localparam logic [2:0] c_fn_and = 3'h2;
   localparam logic [2:0] c_fn_or  = 3'h3;
   localparam logic [2:0] c_fn_slt = 3'h4;

   // Per-stage record tracking the instruction that occupies the stage.
   // An all-zero record is a bubble: it writes nothing and is not a load.
   typedef struct packed {
      logic [c_reg_w-1:0] rd;
      logic               reg_wr;
      logic               mem_rd;
   } stage_rec_t;

   // True when the instruction in a stage produces a value the ID
   // instruction actually consumes. R0 is hardwired to zero, so a write to
   // it never creates a dependency.
   function automatic logic stage_match(
      input stage_rec_t         rec,
      input logic [c_reg_w-1:0] src,
      input logic               uses
   );
      return uses && rec.reg_wr && (rec.rd == src) && (rec.rd != '0);
   endfunction

   // Youngest producer wins: EX holds the most recent value for a register.
   function automatic fwd_sel_e fwd_select(
      input logic ex_hit,
      input logic mem_hit,
      input logic wb_hit
   );
      if (ex_hit)       return FWD_EX;
      else if (mem_hit) return FWD_MEM;
      else if (wb_hit)  return FWD_WB;
      else              return FWD_RF;
   endfunction

endpackage : hazard_unit_pkg
`default_nettype wire

// File: rtl/hazard_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stage_reg
//  Purpose  : One pipeline stage record register. Clears asynchronously on
//             reset; a synchronous bubble input loads an empty record instead
//             of the incoming one.
//  Ports    : clk      - pipeline clock
//             reset    - asynchronous active-high reset (clears to bubble)
//             i_bubble - load an empty record on this edge
//             i_d      - incoming stage record
//             o_q      - current stage record
//  Revision : 1.0  initial release
// ============================================================================
module hazard_stage_reg #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_bubble,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_bubble) begin
         r_q <= '0;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : hazard_stage_reg
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Data-hazard detection and forwarding control for the 5-stage
//             pipeline. Tracks the destination of the instructions in EX,
//             MEM and WB, selects operand forwarding sources for the ID
//             instruction and raises stall for load-use and branch-compare
//             hazards. Counts stalled cycles for performance statistics.
//  Ports    : clk, reset            - clock, async active-high reset
//             IDValid               - ID holds a real instruction
//             IDRs1, IDRs2          - ID source register fields
//             IDUsesRs1, IDUsesRs2  - ID instruction reads that source
//             IDRd                  - ID destination register
//             IDRegWr, IDMemRd      - ID writes a register / is a load
//             IDBranch              - ID compares operands in ID
//             stall                 - hold PC and IF/ID, bubble into ID/EX
//             ForwardA, ForwardB    - operand source select
//             stallCount            - saturating stalled-cycle count
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit
   import hazard_unit_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               IDValid,
   input  logic [c_reg_w-1:0] IDRs1,
   input  logic [c_reg_w-1:0] IDRs2,
   input  logic               IDUsesRs1,
   input  logic               IDUsesRs2,
   input  logic [c_reg_w-1:0] IDRd,
   input  logic               IDRegWr,
   input  logic               IDMemRd,
   input  logic               IDBranch,
   output logic               stall,
   output logic [1:0]         ForwardA,
   output logic [1:0]         ForwardB,
   output logic [15:0]        stallCount
);

   localparam logic [15:0] c_count_max = 16'hFFFF;

   // ------------------------------------------------------------------
   // Stage records
   // ------------------------------------------------------------------
   stage_rec_t w_id_rec;
   stage_rec_t r_ex_rec;
   stage_rec_t r_mem_rec;
   stage_rec_t r_wb_rec;
   logic       w_ex_bubble;
   logic       w_stall;

   assign w_id_rec = '{rd: IDRd, reg_wr: IDRegWr, mem_rd: IDMemRd};

   // A stalled or empty ID slot must not advance into EX as a real
   // instruction, otherwise the held instruction would be issued twice.
   assign w_ex_bubble = w_stall || !IDValid;

   hazard_stage_reg #(.WIDTH(c_stage_w)) u_ex_reg (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (w_ex_bubble),
      .i_d      (w_id_rec),
      .o_q      (r_ex_rec)
   );

   hazard_stage_reg #(.WIDTH(c_stage_w)) u_mem_reg (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (1'b0),
      .i_d      (r_ex_rec),
      .o_q      (r_mem_rec)
   );

   hazard_stage_reg #(.WIDTH(c_stage_w)) u_wb_reg (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (1'b0),
      .i_d      (r_mem_rec),
      .o_q      (r_wb_rec)
   );

   // A load's data is consumed in WB only through forwarding, so the WB
   // record's load flag has no role in hazard decisions.
   logic w_unused_wb_mem_rd;
   assign w_unused_wb_mem_rd = r_wb_rec.mem_rd;

   // ------------------------------------------------------------------
   // Source matches
   // ------------------------------------------------------------------
   logic w_ex_a,  w_ex_b;
   logic w_mem_a, w_mem_b;
   logic w_wb_a,  w_wb_b;

   assign w_ex_a  = stage_match(r_ex_rec,  IDRs1, IDUsesRs1);
   assign w_ex_b  = stage_match(r_ex_rec,  IDRs2, IDUsesRs2);
   assign w_mem_a = stage_match(r_mem_rec, IDRs1, IDUsesRs1);
   assign w_mem_b = stage_match(r_mem_rec, IDRs2, IDUsesRs2);
   assign w_wb_a  = stage_match(r_wb_rec,  IDRs1, IDUsesRs1);
   assign w_wb_b  = stage_match(r_wb_rec,  IDRs2, IDUsesRs2);

   // ------------------------------------------------------------------
   // Stall detection
   // ------------------------------------------------------------------
   logic w_ex_hit;
   logic w_mem_hit;
   logic w_load_use;
   logic w_branch_ex;
   logic w_branch_mem;

   assign w_ex_hit  = w_ex_a  || w_ex_b;
   assign w_mem_hit = w_mem_a || w_mem_b;

   // Load data is not available until the end of MEM.
   assign w_load_use   = r_ex_rec.mem_rd && w_ex_hit;
   // Branches compare in ID, so even an ALU result in EX is one cycle late.
   assign w_branch_ex  = IDBranch && w_ex_hit;
   // A load in MEM is still one cycle late for an ID compare; together with
   // the EX-stage stall this gives a two-cycle load-to-branch penalty.
   assign w_branch_mem = IDBranch && r_mem_rec.mem_rd && w_mem_hit;

   // Reset gating keeps outputs quiet even while records are being cleared.
   assign w_stall = !reset && IDValid &&
                    (w_load_use || w_branch_ex || w_branch_mem);

   // ------------------------------------------------------------------
   // Forward selection
   // ------------------------------------------------------------------
   fwd_sel_e w_fwd_a;
   fwd_sel_e w_fwd_b;

   always_comb begin
      w_fwd_a = FWD_RF;
      w_fwd_b = FWD_RF;
      // During a stall the ID instruction is re-evaluated next cycle, so
      // the current select is meaningless; hold it at the register file.
      if (!reset && !w_stall) begin
         w_fwd_a = fwd_select(w_ex_a, w_mem_a, w_wb_a);
         w_fwd_b = fwd_select(w_ex_b, w_mem_b, w_wb_b);
      end
   end

   // ------------------------------------------------------------------
   // Stalled-cycle counter
   // ------------------------------------------------------------------
   logic [15:0] r_stall_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != c_count_max)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

   assign stall      = w_stall;
   assign ForwardA   = w_fwd_a;
   assign ForwardB   = w_fwd_b;
   assign stallCount = r_stall_count;

endmodule : hazard_unit
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk, reset.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 IDValid  input  1  ID stage holds a real instruction; 0 = bubble or killed slot after killF.
REQ-005 IDRs1, IDRs2  input  3 each  source register fields of the ID instruction.
REQ-006 IDUsesRs1, IDUsesRs2  input  1 each  the ID instruction actually reads that source.
REQ-007 IDRd  input  3  destination register of the ID instruction.
REQ-008 IDRegWr, IDMemRd  input  1 each  ID instruction writes a register / is a load.
REQ-009 IDBranch  input  1  ID instruction compares operands in ID (BEQ, BNE, FOR, RET).
REQ-010 stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-011 ForwardA, ForwardB  output  2 each  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result.
REQ-012 stallCount  output  16  saturating count of stalled cycles, for performance statistics.

Function
REQ-013 SHALL keep three stage records (EX, MEM, WB), each holding {rd, regWr, memRd}.
REQ-014 On each edge: WB takes MEM, MEM takes EX, and EX takes the ID record.
REQ-015 The EX record SHALL load a bubble (regWr=0, memRd=0) when stall=1 or IDValid=0.
REQ-016 A stage matches a source if: regWr=1, rd==src, rd!=0, and the matching IDUses bit is 1.
REQ-017 Forward select priority SHALL be EX (01) > MEM (10) > WB (11) > regfile (00); select is combinational from current records and ID inputs.
REQ-018 Load-use stall: EX record has memRd=1 and matches any used source -> stall=1.
REQ-019 Branch stall, EX stage: IDBranch=1 and the EX record matches a used source (ALU or load) -> stall=1.
REQ-020 Branch stall, MEM stage: IDBranch=1 and the MEM record has memRd=1 and matches a used source -> stall=1.
REQ-021 Net branch stalls: a load followed by a branch SHALL stall 2 cycles; an ALU op followed by a branch SHALL stall 1 cycle.
REQ-022 stall SHALL be 0 whenever IDValid=0.
REQ-023 While stall=1, ForwardA and ForwardB SHALL be 00.
REQ-024 Register 0 SHALL never cause a stall or a forward.
REQ-025 stallCount SHALL increment by 1 on each edge where stall=1, and saturate at 16'hFFFF.
REQ-026 If ID matches several stages, only the youngest stage (highest priority) SHALL drive forwarding; stall evaluation SHALL consider all of REQ-018 to REQ-020.

Reset
REQ-027 reset=1 SHALL clear all stage records to bubbles and clear stallCount to 0, immediately and independent of clk.
REQ-028 While reset=1: stall=0, ForwardA=ForwardB=00, stallCount=0.
REQ-029 Reset asserted mid-stall SHALL terminate the stall; no state SHALL survive reset.

Structure
REQ-030 Forward select codes (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and the register-field width SHALL be placed in a shared include alongside the opcode and function-code definitions.
REQ-031 The stage record register SHALL be one sub-module, hazard_stage_reg (width 5, async reset, synchronous bubble input), instantiated three times.
REQ-032 Match, forwarding and stall logic SHALL be combinational in the top level; the only other register is stallCount.

Verification
REQ-033 ADD R1 in ID, then SUB R2,R1,R3 next cycle -> ForwardA=01, stall=0; one cycle later with an unrelated ID instruction, R1 record is in MEM.
REQ-034 LW R1, then ADD R4,R1,R1 -> stall=1 for exactly 1 cycle, ForwardA=ForwardB=10 on the next cycle, stallCount=1.
REQ-035 LW R2, then BEQ R2,R5 -> stall=1 for 2 consecutive cycles, then ForwardA=11 with stall=0, stallCount=2.
REQ-036 ADDI R0 followed by ADD R1,R0,R0 -> ForwardA=ForwardB=00, stall=0.
REQ-037 R3 written by ID-2 (in MEM) and by ID-1 (in EX), both ALU ops, consumer reads R3 -> ForwardA=01.
REQ-038 Assert reset during the first cycle of a load-use stall -> stall=0 immediately and records cleared; after release, the same consumer with IDValid=1 -> no stall, ForwardA=00.
